// File: rtl/reg64_host_reader.sv
// Host read port onto a bank of 64-bit registers, one 32-bit half per transaction.
// A low-half read snapshots the whole register so the following high-half read is atomic with it.
module reg64_host_reader #(
    parameter int unsigned  NUM_REGS = 6,
    parameter int unsigned  IDX_W    = 3,
    parameter logic [31:0]  ERR_DATA = 32'hDEAD_BEEF,
    localparam int unsigned ADDR_W   = IDX_W + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REGS*64-1:0] reg_in,
    input  logic                   rd_req,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [31:0]            rd_data,
    output logic                   rd_ack,
    output logic                   rd_err,
    output logic                   rd_stale,
    output logic                   busy,
    output logic [15:0]            rd_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ACK
    } state_t;

    localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);

    state_t             state_q,      state_d;
    logic [ADDR_W-1:0]  addr_q,       addr_d;
    logic [63:0]        snap_q,       snap_d;
    logic               snap_valid_q, snap_valid_d;
    logic [IDX_W-1:0]   snap_idx_q,   snap_idx_d;
    logic [31:0]        rd_data_q,    rd_data_d;
    logic               rd_ack_q,     rd_ack_d;
    logic               rd_err_q,     rd_err_d;
    logic               rd_stale_q,   rd_stale_d;
    logic               busy_q,       busy_d;
    logic [15:0]        rd_count_q,   rd_count_d;

    logic [IDX_W-1:0]   addr_idx;
    logic               addr_hi;
    logic               out_of_range;
    logic [63:0]        live_word;

    assign addr_idx     = addr_q[ADDR_W-1:1];
    assign addr_hi      = addr_q[0];
    assign out_of_range = ({1'b0, addr_idx} >= NUM_REGS_W);

    always_comb begin
        live_word = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (addr_idx == IDX_W'(k)) begin
                live_word = reg_in[k*64 +: 64];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q;
        snap_idx_d   = snap_idx_q;
        rd_data_d    = rd_data_q;
        rd_ack_d     = 1'b0;
        rd_err_d     = rd_err_q;
        rd_stale_d   = rd_stale_q;
        rd_count_d   = rd_count_q;

        case (state_q)
            IDLE: begin
                // rd_ack is high during the first IDLE cycle; flags drop with it
                rd_err_d   = 1'b0;
                rd_stale_d = 1'b0;
                if (rd_req) begin
                    addr_d  = rd_addr;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d    = ACK;
                rd_err_d   = 1'b0;
                rd_stale_d = 1'b0;
                if (out_of_range) begin
                    rd_data_d = ERR_DATA;
                    rd_err_d  = 1'b1;
                end else if (!addr_hi) begin
                    snap_d       = live_word;
                    snap_idx_d   = addr_idx;
                    snap_valid_d = 1'b1;
                    rd_data_d    = live_word[31:0];
                end else if (snap_valid_q && (snap_idx_q == addr_idx)) begin
                    rd_data_d    = snap_q[63:32];
                    snap_valid_d = 1'b0;
                end else begin
                    rd_data_d  = live_word[63:32];
                    rd_stale_d = 1'b1;
                end
            end
            ACK: begin
                rd_ack_d = 1'b1;
                if (rd_count_q != 16'hFFFF) begin
                    rd_count_d = rd_count_q + 16'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            snap_idx_q   <= '0;
            rd_data_q    <= '0;
            rd_ack_q     <= 1'b0;
            rd_err_q     <= 1'b0;
            rd_stale_q   <= 1'b0;
            busy_q       <= 1'b0;
            rd_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            snap_idx_q   <= snap_idx_d;
            rd_data_q    <= rd_data_d;
            rd_ack_q     <= rd_ack_d;
            rd_err_q     <= rd_err_d;
            rd_stale_q   <= rd_stale_d;
            busy_q       <= busy_d;
            rd_count_q   <= rd_count_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_ack   = rd_ack_q;
    assign rd_err   = rd_err_q;
    assign rd_stale = rd_stale_q;
    assign busy     = busy_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_reg64_host_reader.sv
// Self-checking bench for reg64_host_reader: directed scenarios followed by
// randomized reads checked against a transaction-level model of the register bank.
module tb_reg64_host_reader;

    localparam int unsigned NUM_REGS = 6;
    localparam int unsigned IDX_W    = 3;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NUM_REGS*64-1:0] reg_in = '0;
    logic                   rd_req = 1'b0;
    logic [IDX_W:0]         rd_addr = '0;
    logic [31:0]            rd_data;
    logic                   rd_ack;
    logic                   rd_err;
    logic                   rd_stale;
    logic                   busy;
    logic [15:0]            rd_count;

    int n_checks = 0;
    int n_fails  = 0;

    logic [63:0] m_reg [NUM_REGS];
    logic [63:0] m_snap;
    logic        m_valid;
    int unsigned m_idx;
    int unsigned m_count;

    reg64_host_reader #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .reg_in   (reg_in),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_ack   (rd_ack),
        .rd_err   (rd_err),
        .rd_stale (rd_stale),
        .busy     (busy),
        .rd_count (rd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input int unsigned k, input logic [63:0] v);
        m_reg[k] = v;
        reg_in[k*64 +: 64] = v;
    endtask

    // Expected response of one read, straight from the bank/snapshot rules.
    task automatic predict(input logic [IDX_W:0] a, output logic [31:0] d,
                           output logic e, output logic s);
        int unsigned idx;
        idx = 32'(a[IDX_W:1]);
        e = 1'b0;
        s = 1'b0;
        if (idx >= NUM_REGS) begin
            d = ERR_DATA;
            e = 1'b1;
        end else if (!a[0]) begin
            d       = m_reg[idx][31:0];
            m_snap  = m_reg[idx];
            m_valid = 1'b1;
            m_idx   = idx;
        end else if (m_valid && m_idx == idx) begin
            d       = m_snap[63:32];
            m_valid = 1'b0;
        end else begin
            d = m_reg[idx][63:32];
            s = 1'b1;
        end
        if (m_count < 65535) m_count++;
    endtask

    // One read; with noise set, extra rd_req pulses are driven while the DUT is busy.
    task automatic do_read(input logic [IDX_W:0] a, input bit noise);
        logic [31:0] ed;
        logic        ee;
        logic        es;
        int          cycles;
        predict(a, ed, ee, es);
        rd_addr = a;
        rd_req  = 1'b1;
        @(posedge clk); #1;
        check("busy_after_accept", 32'(busy), 32'd1);
        rd_req  = noise;
        rd_addr = (IDX_W + 1)'($urandom);
        cycles  = 0;
        while (rd_ack !== 1'b1 && cycles < 8) begin
            @(posedge clk); #1;
            cycles++;
            if (cycles >= 2) rd_req = 1'b0;
        end
        rd_req = 1'b0;
        check("ack_latency", 32'(cycles), 32'd2);
        check("rd_data", rd_data, ed);
        check("rd_err", 32'(rd_err), 32'(ee));
        check("rd_stale", 32'(rd_stale), 32'(es));
        check("rd_count", 32'(rd_count), m_count);
        check("busy_at_ack", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("ack_one_cycle", 32'(rd_ack), 32'd0);
        check("err_cleared", 32'(rd_err), 32'd0);
        check("stale_cleared", 32'(rd_stale), 32'd0);
        check("rd_data_hold", rd_data, ed);
    endtask

    initial begin
        logic [IDX_W:0] a;
        for (int k = 0; k < NUM_REGS; k++) m_reg[k] = '0;
        m_snap  = '0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_count = 0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_rd_ack", 32'(rd_ack), 32'd0);
        check("reset_rd_err", 32'(rd_err), 32'd0);
        check("reset_rd_stale", 32'(rd_stale), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rd_count", 32'(rd_count), 32'd0);

        // Atomic low/high pair survives a register update in between
        set_reg(2, 64'h1122_3344_5566_7788);
        do_read({3'd2, 1'b0}, 1'b0);
        set_reg(2, 64'hAAAA_BBBB_CCCC_DDDD);
        do_read({3'd2, 1'b1}, 1'b0);

        set_reg(1, 64'hCAFE_0000_0000_0001);
        do_read({3'd1, 1'b1}, 1'b0);

        // Snapshot replaced by the second low read
        set_reg(0, 64'h0123_4567_89AB_CDEF);
        set_reg(3, 64'hFEDC_BA98_7654_3210);
        do_read({3'd0, 1'b0}, 1'b0);
        do_read({3'd3, 1'b0}, 1'b0);
        set_reg(0, 64'h5A5A_0000_0000_0000);
        do_read({3'd0, 1'b1}, 1'b0);

        // Out-of-range with dropped busy requests; the reg3 snapshot must survive
        set_reg(3, 64'h0000_1111_2222_3333);
        do_read({3'd7, 1'b0}, 1'b1);
        do_read({3'd6, 1'b1}, 1'b1);
        do_read({3'd3, 1'b1}, 1'b1);

        // Reset in FETCH after a valid snapshot of reg4
        set_reg(4, 64'h4444_0000_4444_0001);
        do_read({3'd4, 1'b0}, 1'b0);
        rd_addr = {3'd4, 1'b0};
        rd_req  = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        reset  = 1'b1;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_ack", 32'(rd_ack), 32'd0);
        check("async_rst_data", rd_data, 32'd0);
        check("async_rst_count", 32'(rd_count), 32'd0);
        @(posedge clk); #1;
        reset   = 1'b0;
        m_valid = 1'b0;
        m_count = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("no_ack_after_abort", 32'(rd_ack), 32'd0);
        end
        do_read({3'd4, 1'b1}, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0)
                set_reg($urandom_range(0, NUM_REGS - 1), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0)
                a = {IDX_W'(m_idx), 1'b1};
            else
                a = (IDX_W + 1)'($urandom);
            do_read(a, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/reg64_host_reader.md
Name: reg64_host_reader

Overview:
- Read-side companion to the team's 64-bit write-enabled datapath registers.
- Gives the 32-bit host/software register bus read access to a bank of NUM_REGS 64-bit registers, one half-word per transaction.
- Reading the low half snapshots the full 64-bit value, so the following high-half read is atomic with it.
- Sits between the register bank outputs and the host read mux.

Parameters:
- NUM_REGS, 6, number of 64-bit registers in reg_in (1..8).
- IDX_W, 3, register-index width; ADDR_W = IDX_W+1.
- ERR_DATA, 32'hDEAD_BEEF, data returned for an out-of-range index.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- reg_in  in  NUM_REGS*64  flattened bank, register k at [64k+63:64k], sampled live.
- rd_req  in  1  read request pulse; accepted only while busy=0.
- rd_addr  in  IDX_W+1  [IDX_W:1] register index, [0] half select (0=low [31:0], 1=high [63:32]).
- rd_data  out  32  read data; valid only while rd_ack=1.
- rd_ack  out  1  one-cycle response strobe.
- rd_err  out  1  qualified by rd_ack: index >= NUM_REGS.
- rd_stale  out  1  qualified by rd_ack: high read not backed by a matching snapshot.
- busy  out  1  transaction in flight; requests ignored.
- rd_count  out  16  completed reads, saturates at 16'hFFFF.

Behaviour:
- Reset values: rd_data=0, rd_ack=0, rd_err=0, rd_stale=0, busy=0, rd_count=0, snap=0, snap_valid=0, snap_idx=0, state=IDLE.
- FSM is IDLE -> FETCH -> ACK -> IDLE, with one cycle per state.
- IDLE: when rd_req=1, latch rd_addr and go to FETCH, with busy=1 from the next cycle. When rd_req=0, stay in IDLE.
- FETCH, index out of range: register rd_data=ERR_DATA and rd_err=1. Snapshot state is unchanged.
- FETCH, low read (addr[0]=0), index in range:
  - snap <= reg_in[idx] (all 64 bits), snap_idx <= idx, snap_valid <= 1.
  - rd_data <= reg_in[idx][31:0].
- FETCH, high read, snap_valid=1 and snap_idx==idx: rd_data <= snap[63:32], rd_stale=0, snap_valid <= 0.
- FETCH, high read, no matching snapshot: rd_data <= live reg_in[idx][63:32] and rd_stale=1. snap_valid is unchanged.
- ACK: rd_ack=1 for exactly one cycle with rd_data/rd_err/rd_stale stable. rd_count increments unless at 16'hFFFF. Then go to IDLE.
- After ACK, rd_ack, rd_err and rd_stale return to 0; rd_data holds its last value.
- Latency: request accepted at edge N gives rd_ack high in the cycle after edge N+2. The next request can be accepted at edge N+3, for a 3-cycle throughput.
- rd_req while busy=1 is dropped, not queued.
- Low read to index A then low read to index B: the snapshot is replaced by B.
- A high read of A after that returns live data with rd_stale=1.
- Changes to reg_in after a low-read snapshot do not affect the following matching high read.
- An out-of-range high read returns ERR_DATA with rd_err=1 and rd_stale=0, and does not clear snap_valid.
- Reset asserted mid-transaction aborts it: no ack is produced, snap_valid=0, and the bench sees all outputs at reset values asynchronously.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, busy=0.
- reg_in[2]=64'h1122_3344_5566_7788; low read idx2 -> rd_ack 3rd cycle after req with rd_data=32'h5566_7788, err=0. Write reg2=64'hAAAA_BBBB_CCCC_DDDD, high read idx2 -> rd_data=32'h1122_3344, stale=0.
- High read idx1 with no prior low read, reg1=64'hCAFE_0000_0000_0001 -> rd_data=32'hCAFE_0000, rd_stale=1.
- Low read idx0, low read idx3, high read idx0 -> third response is live reg0[63:32] with rd_stale=1.
- Read idx7 (NUM_REGS=6) -> rd_data=32'hDEAD_BEEF, rd_err=1. rd_req pulses during busy are dropped, checked by rd_count equal to accepted reads only.
- Assert reset in FETCH -> no rd_ack, snap_valid=0, and a subsequent high read reports rd_stale=1.
